// File: rtl/mem_ctrl_if.sv
// Bundle of request, response and external RAM signals seen by mem_ctrl.
// The controller uses the slave view; the environment drives the master view.
interface mem_ctrl_if;
   logic        rdy;
   logic        has_misbranch;
   logic        read_mem;
   logic        write_mem;
   logic [31:0] mem_addr;
   logic [2:0]  Byte_num;
   logic [31:0] write_data;
   logic        in_mem_ready;
   logic [31:0] in_mem_data;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_data;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   modport slave (
      input  rdy, has_misbranch, read_mem, write_mem, mem_addr, Byte_num, write_data,
             if_req, if_addr, mem_din, io_buffer_full,
      output in_mem_ready, in_mem_data, if_ready, if_data, mem_dout, mem_a, mem_wr
   );

   modport master (
      output rdy, has_misbranch, read_mem, write_mem, mem_addr, Byte_num, write_data,
             if_req, if_addr, mem_din, io_buffer_full,
      input  in_mem_ready, in_mem_data, if_ready, if_data, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises load/store and fetch requests into byte transfers on the external RAM
// port; load/store has priority, a misbranch kills reads but never a store.
module mem_ctrl (
   input  logic clk,
   input  logic rst,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic        wr;
   } ls_req_t;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        ls_pend_q, ls_pend_d;
   ls_req_t     ls_q, ls_d;
   logic        if_pend_q, if_pend_d;
   logic [31:0] if_addr_q, if_addr_d;
   logic [31:0] cur_addr_q, cur_addr_d;
   logic [2:0]  cur_size_q, cur_size_d;
   logic [31:0] cur_wdata_q, cur_wdata_d;
   logic        cur_fetch_q, cur_fetch_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        mem_wr_q, mem_wr_d;
   logic        ls_rdy_q, ls_rdy_d;
   logic [31:0] ls_data_q, ls_data_d;
   logic        if_rdy_q, if_rdy_d;
   logic [31:0] if_data_q, if_data_d;

   logic        misb, last, io_block, ls_go;
   logic [2:0]  cnt_nx;

   assign misb     = bus.has_misbranch;
   assign cnt_nx   = cnt_q + 3'd1;
   assign last     = ({1'b0, cnt_q} + 4'd1) >= {1'b0, cur_size_q};
   // UART-mapped stores wait while the UART buffer is full
   assign io_block = ls_q.wr && (ls_q.addr[17:16] == 2'b11) && bus.io_buffer_full;
   assign ls_go    = ls_pend_q && !io_block && (ls_q.wr || !misb);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ls_pend_d   = ls_pend_q;
      ls_d        = ls_q;
      if_pend_d   = if_pend_q;
      if_addr_d   = if_addr_q;
      cur_addr_d  = cur_addr_q;
      cur_size_d  = cur_size_q;
      cur_wdata_d = cur_wdata_q;
      cur_fetch_d = cur_fetch_q;
      acc_d       = acc_q;
      mem_a_d     = mem_a_q;
      mem_dout_d  = mem_dout_q;
      mem_wr_d    = mem_wr_q;
      ls_rdy_d    = 1'b0;
      ls_data_d   = ls_data_q;
      if_rdy_d    = 1'b0;
      if_data_d   = if_data_q;

      if (bus.rdy) begin
         unique case (state_q)
            IDLE: begin
               if (ls_go) begin
                  ls_pend_d   = 1'b0;
                  cur_addr_d  = ls_q.addr;
                  cur_size_d  = ls_q.size;
                  cur_wdata_d = ls_q.wdata;
                  cur_fetch_d = 1'b0;
                  cnt_d       = 3'd0;
                  acc_d       = 32'd0;
                  mem_a_d     = ls_q.addr;
                  if (ls_q.wr) begin
                     state_d    = WRITE;
                     mem_dout_d = ls_q.wdata[7:0];
                     mem_wr_d   = 1'b1;
                  end else begin
                     state_d    = READ;
                  end
               end else if (if_pend_q && !misb) begin
                  if_pend_d   = 1'b0;
                  cur_addr_d  = if_addr_q;
                  cur_size_d  = 3'd4;
                  cur_wdata_d = 32'd0;
                  cur_fetch_d = 1'b1;
                  cnt_d       = 3'd0;
                  acc_d       = 32'd0;
                  mem_a_d     = if_addr_q;
                  state_d     = READ;
               end
            end
            READ: begin
               if (misb) begin
                  state_d = IDLE;
               end else begin
                  // byte for mem_a driven last edge is on mem_din now
                  acc_d[{cnt_q[1:0], 3'b000} +: 8] = bus.mem_din;
                  if (last) begin
                     state_d = IDLE;
                     if (cur_fetch_q) begin
                        if_rdy_d  = 1'b1;
                        if_data_d = acc_d;
                     end else begin
                        ls_rdy_d  = 1'b1;
                        ls_data_d = acc_d;
                     end
                  end else begin
                     cnt_d   = cnt_nx;
                     mem_a_d = cur_addr_q + {29'd0, cnt_nx};
                  end
               end
            end
            WRITE: begin
               if (last) begin
                  state_d   = IDLE;
                  mem_wr_d  = 1'b0;
                  ls_rdy_d  = 1'b1;
                  ls_data_d = 32'd0;
               end else begin
                  cnt_d      = cnt_nx;
                  mem_a_d    = cur_addr_q + {29'd0, cnt_nx};
                  mem_dout_d = cur_wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                  mem_wr_d   = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         if (misb) begin
            if_pend_d = 1'b0;
            if (!ls_q.wr) ls_pend_d = 1'b0;
         end

         // new pulses are latched after the flush so a same-cycle store survives
         if (bus.write_mem) begin
            ls_pend_d = 1'b1;
            ls_d      = '{addr: bus.mem_addr, size: bus.Byte_num, wdata: bus.write_data, wr: 1'b1};
         end else if (bus.read_mem && !misb) begin
            ls_pend_d = 1'b1;
            ls_d      = '{addr: bus.mem_addr, size: bus.Byte_num, wdata: bus.write_data, wr: 1'b0};
         end
         if (bus.if_req && !misb) begin
            if_pend_d = 1'b1;
            if_addr_d = bus.if_addr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         ls_pend_q   <= 1'b0;
         ls_q        <= '0;
         if_pend_q   <= 1'b0;
         if_addr_q   <= 32'd0;
         cur_addr_q  <= 32'd0;
         cur_size_q  <= 3'd0;
         cur_wdata_q <= 32'd0;
         cur_fetch_q <= 1'b0;
         acc_q       <= 32'd0;
         mem_a_q     <= 32'd0;
         mem_dout_q  <= 8'd0;
         mem_wr_q    <= 1'b0;
         ls_rdy_q    <= 1'b0;
         ls_data_q   <= 32'd0;
         if_rdy_q    <= 1'b0;
         if_data_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ls_pend_q   <= ls_pend_d;
         ls_q        <= ls_d;
         if_pend_q   <= if_pend_d;
         if_addr_q   <= if_addr_d;
         cur_addr_q  <= cur_addr_d;
         cur_size_q  <= cur_size_d;
         cur_wdata_q <= cur_wdata_d;
         cur_fetch_q <= cur_fetch_d;
         acc_q       <= acc_d;
         mem_a_q     <= mem_a_d;
         mem_dout_q  <= mem_dout_d;
         mem_wr_q    <= mem_wr_d;
         ls_rdy_q    <= ls_rdy_d;
         ls_data_q   <= ls_data_d;
         if_rdy_q    <= if_rdy_d;
         if_data_q   <= if_data_d;
      end
   end

   assign bus.mem_a        = mem_a_q;
   assign bus.mem_dout     = mem_dout_q;
   assign bus.mem_wr       = mem_wr_q & bus.rdy;
   assign bus.in_mem_ready = ls_rdy_q;
   assign bus.in_mem_data  = ls_data_q;
   assign bus.if_ready     = if_rdy_q;
   assign bus.if_data      = if_data_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the load/store buffer, the instruction fetcher and the byte-wide external RAM port. It latches single-cycle read/write pulses from the load/store buffer and fetch requests from the fetcher, then serialises each access into 1–4 byte transfers on the RAM bus. It returns the assembled little-endian word with a one-cycle ready pulse. Load/store requests take priority over fetch; a misbranch kills reads but never a store.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state and forces mem_wr=0
- has_misbranch  in  1  flush pulse
- read_mem  in  1  load request pulse from load/store buffer
- write_mem  in  1  store request pulse from load/store buffer
- mem_addr  in  32  load/store byte address
- Byte_num  in  3  access size: 1, 2 or 4
- write_data  in  32  store data, low Byte_num bytes valid
- in_mem_ready  out  1  one-cycle completion pulse to load/store buffer
- in_mem_data  out  32  load result, zero-extended; 0 for stores
- if_req  in  1  fetch request pulse (always 4 bytes)
- if_addr  in  32  fetch address
- if_ready  out  1  one-cycle fetch completion pulse
- if_data  out  32  fetched instruction
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write enable
- io_buffer_full  in  1  UART buffer full

## Operation
- Request latching:
  - read_mem/write_mem set ls_pend and capture addr/size/data/type.
  - if_req sets if_pend and captures if_addr.
  - At most one outstanding of each.
- States:
  - IDLE: select ls_pend over if_pend, then go to READ or WRITE with cnt=0; clear the selected pending flag.
  - READ: lasts N+1 cycles.
  - WRITE: lasts N cycles plus one completion edge.
- Read:
  - Edge k (k=0..N-1) drives mem_a=addr+k.
  - Byte from address addr+k appears on mem_din one cycle after it was driven. Capture it into bits [8k+7:8k] at edge k+1.
  - At edge N: pulse in_mem_ready (load) or if_ready (fetch) with the assembled data, and return to IDLE.
  - Upper bytes are zero.
- Write:
  - Edge k drives mem_a=addr+k, mem_dout=write_data[8k+7:8k], mem_wr=1.
  - At edge N: mem_wr=0, in_mem_ready=1, in_mem_data=0, return to IDLE.
- IO hold-off: a pending store with mem_addr[17:16]==2'b11 is not started while io_buffer_full=1. It remains pending; fetch may proceed meanwhile.
- Misbranch:
  - Clear if_pend and a pending load.
  - Abort an active READ to IDLE with no ready pulse.
  - A pending or active store is preserved and completes normally.
  - A request pulse in the same cycle as has_misbranch is dropped, except a store.
- Ready pulses last exactly one cycle and are never both high in one cycle.
- Address arithmetic is 32-bit wrap-around.

## Timing
- Reset values:
  - Outputs: mem_a=0, mem_dout=0, mem_wr=0, in_mem_ready=0, in_mem_data=0, if_ready=0, if_data=0.
  - Internal: state=IDLE, ls_pend=0, if_pend=0.
- Latency counted from the request pulse edge P:
  - Start edge is P+1.
  - Read completion is visible in the cycle after edge P+1+N.
  - Write completion follows the same count.
  - Examples: lw/sw = 6 cycles; fetch = 6 cycles; lb/sb = 3 cycles.
- A request pulsed in the same cycle as the ready pulse is latched, starting no earlier than the next IDLE edge.
- If a load/store and a fetch are pulsed together, the load/store starts first and the fetch starts at the first IDLE edge after it completes.
- rdy=0 mid-transfer:
  - cnt, state and outputs hold; mem_wr=0.
  - Resume on rdy=1 without repeating or skipping a byte.
- rst mid-transfer: immediate return to reset values; the partial access is abandoned.

## Test plan
- lw 0x100, RAM[0x100..0x103]=0x78,0x56,0x34,0x12 -> mem_a walks 0x100..0x103; in_mem_ready pulses once with in_mem_data=0x12345678, 6 cycles after the pulse.
- sh addr 0x200, write_data=0xDEADBEEF -> exactly two mem_wr=1 cycles: (0x200,0xEF) then (0x201,0xBE); in_mem_ready then pulses; no write to 0x202.
- lbu and fetch pulsed same cycle, RAM[0x10]=0xFF, if_addr=0x0 -> load completes first with in_mem_data=0x000000FF; fetch completes afterwards with the correct word; never both ready in one cycle.
- Fetch in progress after 2 bytes, has_misbranch=1 -> state IDLE next edge, if_ready never pulses; a new fetch afterwards returns correct data.
- sb to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0 throughout; after deassert, one write of (0x30000, byte) and an in_mem_ready pulse.
- rdy=0 for 3 cycles in the middle of an lw -> mem_a holds and no byte is repeated or skipped; result identical to the uninterrupted case, delayed by 3 cycles.
